// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: shared prescaled counter (edge or centre aligned),
// per-channel shadowed duty compare, output enable/inversion and period-end strobe.
module pwm_multichannel #(
  parameter  int unsigned NUM_CH  = 16,
  parameter  int unsigned RES     = 8,
  parameter  int unsigned PRESC_W = 12,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               center_mode,
  input  logic [NUM_CH-1:0]  out_en,
  input  logic [NUM_CH-1:0]  pwm_en,
  input  logic [NUM_CH-1:0]  invert,
  input  logic               duty_wr,
  input  logic [CH_W-1:0]    duty_wr_ch,
  input  logic [RES-1:0]     duty_wr_data,
  output logic               period_end,
  output logic [NUM_CH-1:0]  out
);

  localparam logic [RES-1:0] MAX = {RES{1'b1}};
  localparam logic [RES-1:0] ONE = RES'(1);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [RES-1:0]     cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               mode_q, mode_d;
  logic [RES-1:0]     shadow_q [NUM_CH];
  logic [RES-1:0]     shadow_d [NUM_CH];
  logic [RES-1:0]     active_q [NUM_CH];
  logic [RES-1:0]     active_d [NUM_CH];
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               period_end_q, period_end_d;

  logic [PRESC_W-1:0] presc_n;
  logic               mode_chg;
  logic               tick;
  logic               boundary;
  logic               wr_ok;

  always_comb begin
    presc_cnt_d  = presc_cnt_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    mode_d       = center_mode;
    shadow_d     = shadow_q;
    active_d     = active_q;
    out_d        = '0;
    boundary     = 1'b0;
    mode_chg     = (center_mode != mode_q);
    presc_n      = (prescale == '0) ? PRESC_W'(1) : prescale;
    // >= keeps the divider from running away if prescale shrinks mid-count
    tick         = ena && !mode_chg && (presc_cnt_q >= (presc_n - PRESC_W'(1)));
    wr_ok        = duty_wr && (32'(duty_wr_ch) < NUM_CH);

    if (wr_ok) begin
      shadow_d[duty_wr_ch] = duty_wr_data;
    end

    if (mode_chg) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_d       = 1'b0;
    end else if (ena) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
      if (tick) begin
        if (!mode_q) begin
          cnt_d    = cnt_q + ONE;
          dir_d    = 1'b0;
          boundary = (cnt_q == MAX);
        end else if (!dir_q) begin
          if (cnt_q == MAX) begin
            cnt_d = MAX - ONE;
            dir_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            dir_d    = 1'b0;
            boundary = 1'b1;
          end
        end
      end
    end

    // Reload from shadow_d so a write on the boundary cycle lands in the new period
    if (boundary) begin
      active_d = shadow_d;
    end

    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ena && out_en[i]) begin
        out_d[i] = (pwm_en[i] ? ((active_q[i] == MAX) || (cnt_q < active_q[i])) : 1'b1)
                   ^ invert[i];
      end
    end

    period_end_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q  <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      mode_q       <= center_mode;
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      out_q        <= '0;
      period_end_q <= 1'b0;
    end else begin
      presc_cnt_q  <= presc_cnt_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      out_q        <= out_d;
      period_end_q <= period_end_d;
    end
  end

  assign out        = out_q;
  assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: period-level vector table, corner-case
// sequences and randomized traffic against a tick-count reference model.
module tb_pwm_multichannel;

  localparam int NUM_CH  = 16;
  localparam int RES     = 8;
  localparam int PRESC_W = 12;
  localparam int CH_W    = 4;
  localparam int MAX     = 255;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ena = 1'b1;
  logic [PRESC_W-1:0] prescale = PRESC_W'(1);
  logic               center_mode = 1'b0;
  logic [NUM_CH-1:0]  out_en = '1;
  logic [NUM_CH-1:0]  pwm_en = '1;
  logic [NUM_CH-1:0]  invert = '0;
  logic               duty_wr = 1'b0;
  logic [CH_W-1:0]    duty_wr_ch = '0;
  logic [RES-1:0]     duty_wr_data = '0;
  logic               period_end;
  logic [NUM_CH-1:0]  out;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pwm_multichannel #(.NUM_CH(NUM_CH), .RES(RES), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .prescale(prescale), .center_mode(center_mode),
    .out_en(out_en), .pwm_en(pwm_en), .invert(invert), .duty_wr(duty_wr),
    .duty_wr_ch(duty_wr_ch), .duty_wr_data(duty_wr_data),
    .period_end(period_end), .out(out)
  );

  // Reference model: counter value derived from tick count within the period
  int                m_presc, m_ticks;
  bit                m_mode;
  int                m_shadow [NUM_CH];
  int                m_active [NUM_CH];
  logic [NUM_CH-1:0] exp_out = '0;
  bit                exp_pe = 1'b0;

  function automatic int cnt_of(input int t, input bit md);
    if (!md) return t;
    return (t <= MAX) ? t : 2 * MAX - t;
  endfunction

  always @(posedge clk) begin : model
    int c, n, per;
    bit raw;
    logic [NUM_CH-1:0] eo;
    if (rst) begin
      m_presc = 0; m_ticks = 0; m_mode = center_mode;
      for (int i = 0; i < NUM_CH; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      exp_out = '0; exp_pe = 1'b0;
    end else begin
      c = cnt_of(m_ticks, m_mode);
      eo = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        raw = pwm_en[i] ? ((m_active[i] == MAX) || (c < m_active[i])) : 1'b1;
        if (ena && out_en[i]) eo[i] = raw ^ invert[i];
      end
      exp_out = eo;
      if (duty_wr && int'(duty_wr_ch) < NUM_CH) m_shadow[duty_wr_ch] = int'(duty_wr_data);
      exp_pe = 1'b0;
      if (center_mode != m_mode) begin
        m_mode = center_mode; m_presc = 0; m_ticks = 0;
      end else if (ena) begin
        n = (prescale == 0) ? 1 : int'(prescale);
        if (m_presc + 1 >= n) begin
          m_presc = 0;
          per = m_mode ? 2 * MAX : MAX + 1;
          m_ticks = (m_ticks + 1) % per;
          if (cnt_of(m_ticks, m_mode) == 0) begin
            exp_pe = 1'b1;
            for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, expv, expv, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
    check("model_out_pe", int'({period_end, out}), int'({exp_pe, exp_out}));
  endtask

  task automatic do_reset(input bit md, input int presc);
    rst = 1'b1; center_mode = md; prescale = PRESC_W'(presc); duty_wr = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wr_duty(input int ch, input int val);
    duty_wr = 1'b1; duty_wr_ch = CH_W'(ch); duty_wr_data = RES'(val);
    cyc();
    duty_wr = 1'b0;
  endtask

  task automatic wait_pe(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1200 && !ok; i++) begin
      cyc();
      if (period_end) ok = 1'b1;
    end
    check(name, int'(ok), 1);
  endtask

  typedef struct {
    bit    center;
    int    ch;
    int    duty;
    bit    inv;
    int    exp_high;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int hi, pe, lowok, cnt;

    vecs[0]  = '{0, 0,  64,  0, 64};
    vecs[1]  = '{0, 3,  0,   0, 0};
    vecs[2]  = '{0, 3,  255, 0, 256};
    vecs[3]  = '{0, 3,  0,   1, 256};
    vecs[4]  = '{0, 3,  255, 1, 0};
    vecs[5]  = '{0, 5,  64,  1, 192};
    vecs[6]  = '{0, 15, 254, 0, 254};
    vecs[7]  = '{1, 0,  100, 0, 199};
    vecs[8]  = '{1, 3,  255, 0, 510};
    vecs[9]  = '{1, 3,  0,   0, 0};
    vecs[10] = '{1, 7,  100, 1, 311};
    vecs[11] = '{1, 9,  1,   0, 1};

    // Reset state
    do_reset(1'b0, 1);
    check("reset_out", int'(out), 0);
    check("reset_pe", int'(period_end), 0);

    // Full-period duty measurements
    foreach (vecs[k]) begin
      ena = 1'b1; out_en = '1; pwm_en = '1;
      invert = '0; invert[vecs[k].ch] = vecs[k].inv;
      do_reset(vecs[k].center, 1);
      wr_duty(vecs[k].ch, vecs[k].duty);
      wait_pe($sformatf("vec%0d_first_pe", k));
      hi = 0; pe = 0;
      for (int i = 0; i < (vecs[k].center ? 2 * MAX : MAX + 1); i++) begin
        cyc();
        hi += int'(out[vecs[k].ch]);
        pe += int'(period_end);
      end
      check($sformatf("vec%0d_high_cycles", k), hi, vecs[k].exp_high);
      check($sformatf("vec%0d_pe_per_period", k), pe, 1);
    end
    invert = '0;

    // Shadowed update: mid-period write waits, boundary write is immediate
    do_reset(1'b0, 1);
    wr_duty(2, 50);
    wait_pe("shadow_first_pe");
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      duty_wr = 1'b0;
      hi += int'(out[2]);
      if (i == 100) begin duty_wr = 1'b1; duty_wr_ch = 2; duty_wr_data = 200; end
    end
    check("shadow_old_duty_holds", hi, 50);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      duty_wr = 1'b0;
      hi += int'(out[2]);
      if (i == 254) begin duty_wr = 1'b1; duty_wr_ch = 2; duty_wr_data = 10; end
      if (i == 255) check("boundary_write_pe", int'(period_end), 1);
    end
    check("shadow_new_duty", hi, 200);
    hi = 0;
    for (int i = 0; i < 256; i++) begin cyc(); hi += int'(out[2]); end
    check("boundary_write_through", hi, 10);

    // Large prescaler with enable gap: counting must freeze and resume exactly
    do_reset(1'b0, 1);
    wr_duty(0, 2);
    wait_pe("presc_first_pe");
    prescale = PRESC_W'(3334);
    hi = 0; pe = 0; lowok = 1;
    for (int i = 0; i < 2000; i++) begin cyc(); hi += int'(out[0]); pe += int'(period_end); end
    ena = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (out != '0) lowok = 0;
      pe += int'(period_end);
    end
    check("ena_low_out_zero", lowok, 1);
    ena = 1'b1;
    for (int i = 0; i < 6000; i++) begin cyc(); hi += int'(out[0]); pe += int'(period_end); end
    check("presc_high_cycles", hi, 6668);
    check("presc_no_pe", pe, 0);

    // Reset mid-period discards shadow writes; mode flip restarts the period
    prescale = PRESC_W'(1);
    do_reset(1'b1, 1);
    wr_duty(0, 120);
    for (int i = 0; i < 300; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midreset_out", int'(out), 0);
    wait_pe("midreset_pe");
    hi = 0;
    for (int i = 0; i < 2 * MAX; i++) begin cyc(); hi += int'(out[0]); end
    check("midreset_shadow_lost", hi, 0);
    wr_duty(1, 30);
    for (int i = 0; i < 100; i++) cyc();
    center_mode = 1'b0;
    cnt = 0; pe = 0;
    for (int i = 0; i < 600 && pe == 0; i++) begin
      cyc(); cnt++;
      if (period_end) pe = 1;
    end
    check("modeflip_pe_latency", cnt, 257);

    // Randomized traffic against the model
    for (int seg = 0; seg < 3; seg++) begin
      ena = 1'b1; out_en = NUM_CH'($urandom); pwm_en = NUM_CH'($urandom); invert = NUM_CH'($urandom);
      do_reset(1'($urandom), $urandom_range(0, 3));
      for (int i = 0; i < 1500; i++) begin
        duty_wr = 1'b0; rst = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          duty_wr = 1'b1; duty_wr_ch = CH_W'($urandom);
          case ($urandom_range(0, 3))
            0: duty_wr_data = '0;
            1: duty_wr_data = '1;
            default: duty_wr_data = RES'($urandom);
          endcase
        end
        if ($urandom_range(0, 49) == 0) begin
          out_en = NUM_CH'($urandom); pwm_en = NUM_CH'($urandom | $urandom); invert = NUM_CH'($urandom);
        end
        if ($urandom_range(0, 199) == 0) ena = ~ena;
        if ($urandom_range(0, 399) == 0) center_mode = ~center_mode;
        if ($urandom_range(0, 599) == 0) rst = 1'b1;
        cyc();
      end
      duty_wr = 1'b0; rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
